// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: stall/flush/bubble generation, EX operand forward select, post-WB buffer.
// Define HAZARD_FWD_EN for the forwarding build; otherwise every RAW dependency is resolved by stalling.
module hazard_ctrl_unit #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [RA_W-1:0] ID_RS1_ADDR,
    input  logic [RA_W-1:0] ID_RS2_ADDR,
    input  logic            ID_RS1_USED,
    input  logic            ID_RS2_USED,
    input  logic [RA_W-1:0] EX_RD_ADDR,
    input  logic            EX_REG_WRITE_EN,
    input  logic            EX_IS_LOAD,
    input  logic [RA_W-1:0] MEM_RD_ADDR,
    input  logic            MEM_REG_WRITE_EN,
    input  logic [RA_W-1:0] WB_RD_ADDR,
    input  logic            WB_REG_WRITE_EN,
    input  logic [XLEN-1:0] WB_VALUE,
    input  logic            EX_BJ_SIG,
    input  logic            INSTR_MEM_BUSYWAIT,
    input  logic            DATA_MEM_BUSYWAIT,
    output logic            PC_STALL,
    output logic            IF_ID_STALL,
    output logic            IF_ID_FLUSH,
    output logic            ID_EX_STALL,
    output logic            ID_EX_BUBBLE,
    output logic            EX_MEM_STALL,
    output logic            MEM_WB_STALL,
    output logic [1:0]      FWD_SEL1,
    output logic [1:0]      FWD_SEL2,
    output logic [XLEN-1:0] POSTWB_VALUE
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LD_STALL  = 2'd1,
        DMEM_WAIT = 2'd2,
        RAW_WAIT  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic w_ex_hit;
    logic w_load_use;
    logic w_hazard;
    logic w_wb_capture;

    function automatic logic src_hit(input logic [RA_W-1:0] src, input logic used,
                                     input logic [RA_W-1:0] rd, input logic we);
        return used && we && (rd != '0) && (src == rd);
    endfunction

    assign w_ex_hit   = src_hit(ID_RS1_ADDR, ID_RS1_USED, EX_RD_ADDR, EX_REG_WRITE_EN) ||
                        src_hit(ID_RS2_ADDR, ID_RS2_USED, EX_RD_ADDR, EX_REG_WRITE_EN);
    assign w_load_use = EX_IS_LOAD && w_ex_hit;

`ifdef HAZARD_FWD_EN
    // LD_STALL suppresses re-detection so a load-use stall lasts exactly one cycle.
    assign w_hazard = w_load_use && (r_state != LD_STALL);
`else
    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = src_hit(ID_RS1_ADDR, ID_RS1_USED, MEM_RD_ADDR, MEM_REG_WRITE_EN) ||
                       src_hit(ID_RS2_ADDR, ID_RS2_USED, MEM_RD_ADDR, MEM_REG_WRITE_EN);
    assign w_wb_hit  = src_hit(ID_RS1_ADDR, ID_RS1_USED, WB_RD_ADDR, WB_REG_WRITE_EN) ||
                       src_hit(ID_RS2_ADDR, ID_RS2_USED, WB_RD_ADDR, WB_REG_WRITE_EN);
    assign w_hazard  = w_ex_hit || w_mem_hit || w_wb_hit || w_load_use;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        PC_STALL     = 1'b0;
        IF_ID_STALL  = 1'b0;
        IF_ID_FLUSH  = 1'b0;
        ID_EX_STALL  = 1'b0;
        ID_EX_BUBBLE = 1'b0;
        EX_MEM_STALL = 1'b0;
        MEM_WB_STALL = 1'b0;
        if (DATA_MEM_BUSYWAIT) begin
            w_next       = DMEM_WAIT;
            PC_STALL     = 1'b1;
            IF_ID_STALL  = 1'b1;
            ID_EX_STALL  = 1'b1;
            EX_MEM_STALL = 1'b1;
            MEM_WB_STALL = 1'b1;
        end else if (EX_BJ_SIG) begin
            w_next       = RUN;
            IF_ID_FLUSH  = 1'b1;
            ID_EX_BUBBLE = 1'b1;
        end else if (w_hazard) begin
`ifdef HAZARD_FWD_EN
            w_next       = LD_STALL;
`else
            w_next       = RAW_WAIT;
`endif
            PC_STALL     = 1'b1;
            IF_ID_STALL  = 1'b1;
            ID_EX_BUBBLE = 1'b1;
        end else begin
            w_next       = RUN;
            PC_STALL     = INSTR_MEM_BUSYWAIT;
            IF_ID_FLUSH  = INSTR_MEM_BUSYWAIT;
        end
    end

    assign w_wb_capture = WB_REG_WRITE_EN && (WB_RD_ADDR != '0);

    logic [XLEN-1:0] r_pwb_value;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pwb_value <= '0;
        end else if (!MEM_WB_STALL && w_wb_capture) begin
            r_pwb_value <= WB_VALUE;
        end
    end

    assign POSTWB_VALUE = r_pwb_value;

`ifdef HAZARD_FWD_EN
    logic [1:0]      r_fwd_sel1;
    logic [1:0]      r_fwd_sel2;
    logic            r_pwb_valid;
    logic [RA_W-1:0] r_pwb_addr;
    logic [1:0]      w_sel1;
    logic [1:0]      w_sel2;

    function automatic logic [1:0] fwd_src(input logic [RA_W-1:0] src,
                                           input logic [RA_W-1:0] mem_rd, input logic mem_we,
                                           input logic [RA_W-1:0] wb_rd,  input logic wb_we,
                                           input logic pwb_valid, input logic [RA_W-1:0] pwb_addr);
        if (src_hit(src, 1'b1, mem_rd, mem_we)) begin
            return 2'b01;
        end else if (src_hit(src, 1'b1, wb_rd, wb_we)) begin
            return 2'b10;
        end else if (src_hit(src, 1'b1, pwb_addr, pwb_valid)) begin
            return 2'b11;
        end
        return 2'b00;
    endfunction

    assign w_sel1 = fwd_src(ID_RS1_ADDR, MEM_RD_ADDR, MEM_REG_WRITE_EN, WB_RD_ADDR,
                            WB_REG_WRITE_EN, r_pwb_valid, r_pwb_addr);
    assign w_sel2 = fwd_src(ID_RS2_ADDR, MEM_RD_ADDR, MEM_REG_WRITE_EN, WB_RD_ADDR,
                            WB_REG_WRITE_EN, r_pwb_valid, r_pwb_addr);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_fwd_sel1  <= '0;
            r_fwd_sel2  <= '0;
            r_pwb_valid <= 1'b0;
            r_pwb_addr  <= '0;
        end else begin
            if (!ID_EX_STALL) begin
                r_fwd_sel1 <= ID_EX_BUBBLE ? 2'b00 : w_sel1;
                r_fwd_sel2 <= ID_EX_BUBBLE ? 2'b00 : w_sel2;
            end
            if (!MEM_WB_STALL) begin
                r_pwb_valid <= w_wb_capture;
                if (w_wb_capture) begin
                    r_pwb_addr <= WB_RD_ADDR;
                end
            end
        end
    end

    assign FWD_SEL1 = r_fwd_sel1;
    assign FWD_SEL2 = r_fwd_sel2;
`else
    assign FWD_SEL1 = 2'b00;
    assign FWD_SEL2 = 2'b00;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: vector table, directed sequences, randomized run vs. reference model.
// Expectations follow the build: HAZARD_FWD_EN selects the forwarding behaviour.
module tb_hazard_ctrl_unit;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // {PC_STALL, IF_ID_STALL, IF_ID_FLUSH, ID_EX_STALL, ID_EX_BUBBLE, EX_MEM_STALL, MEM_WB_STALL}
    localparam logic [6:0] S_NONE = 7'b0000000;
    localparam logic [6:0] S_HAZ  = 7'b1100100;
    localparam logic [6:0] S_BJ   = 7'b0010100;
    localparam logic [6:0] S_IM   = 7'b1010000;
    localparam logic [6:0] S_DM   = 7'b1101011;

    logic        CLK, RESET;
    logic [4:0]  ID_RS1_ADDR, ID_RS2_ADDR, EX_RD_ADDR, MEM_RD_ADDR, WB_RD_ADDR;
    logic        ID_RS1_USED, ID_RS2_USED, EX_REG_WRITE_EN, EX_IS_LOAD;
    logic        MEM_REG_WRITE_EN, WB_REG_WRITE_EN;
    logic [31:0] WB_VALUE;
    logic        EX_BJ_SIG, INSTR_MEM_BUSYWAIT, DATA_MEM_BUSYWAIT;
    logic        PC_STALL, IF_ID_STALL, IF_ID_FLUSH, ID_EX_STALL, ID_EX_BUBBLE;
    logic        EX_MEM_STALL, MEM_WB_STALL;
    logic [1:0]  FWD_SEL1, FWD_SEL2;
    logic [31:0] POSTWB_VALUE;
    logic [6:0]  ctl;

    hazard_ctrl_unit #(.XLEN(32), .RA_W(5)) dut (
        .CLK(CLK), .RESET(RESET),
        .ID_RS1_ADDR(ID_RS1_ADDR), .ID_RS2_ADDR(ID_RS2_ADDR),
        .ID_RS1_USED(ID_RS1_USED), .ID_RS2_USED(ID_RS2_USED),
        .EX_RD_ADDR(EX_RD_ADDR), .EX_REG_WRITE_EN(EX_REG_WRITE_EN), .EX_IS_LOAD(EX_IS_LOAD),
        .MEM_RD_ADDR(MEM_RD_ADDR), .MEM_REG_WRITE_EN(MEM_REG_WRITE_EN),
        .WB_RD_ADDR(WB_RD_ADDR), .WB_REG_WRITE_EN(WB_REG_WRITE_EN), .WB_VALUE(WB_VALUE),
        .EX_BJ_SIG(EX_BJ_SIG), .INSTR_MEM_BUSYWAIT(INSTR_MEM_BUSYWAIT),
        .DATA_MEM_BUSYWAIT(DATA_MEM_BUSYWAIT),
        .PC_STALL(PC_STALL), .IF_ID_STALL(IF_ID_STALL), .IF_ID_FLUSH(IF_ID_FLUSH),
        .ID_EX_STALL(ID_EX_STALL), .ID_EX_BUBBLE(ID_EX_BUBBLE),
        .EX_MEM_STALL(EX_MEM_STALL), .MEM_WB_STALL(MEM_WB_STALL),
        .FWD_SEL1(FWD_SEL1), .FWD_SEL2(FWD_SEL2), .POSTWB_VALUE(POSTWB_VALUE)
    );

    assign ctl = {PC_STALL, IF_ID_STALL, IF_ID_FLUSH, ID_EX_STALL, ID_EX_BUBBLE,
                  EX_MEM_STALL, MEM_WB_STALL};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]  rs1, rs2, exrd, memrd, wbrd;
        logic        u1, u2, exwe, exld, memwe, wbwe, bj, im, dm;
        logic [31:0] wbval;
    } in_t;

    typedef struct {
        in_t        i;
        logic [6:0] ef;
        logic [6:0] en;
    } vec_t;

    int checks;
    int failures;

    // reference model history
    bit          m_ld;
    bit          m_pv;
    logic [4:0]  m_pa;
    logic [31:0] m_val;
    logic [1:0]  m_f1, m_f2;

    function automatic in_t mk(input int rs1, input int u1, input int rs2, input int u2,
                               input int exrd, input int exwe, input int exld,
                               input int memrd, input int memwe, input int wbrd, input int wbwe,
                               input int bj, input int im, input int dm);
        in_t r;
        r.rs1 = 5'(rs1);   r.u1 = 1'(u1);     r.rs2 = 5'(rs2);   r.u2 = 1'(u2);
        r.exrd = 5'(exrd); r.exwe = 1'(exwe); r.exld = 1'(exld);
        r.memrd = 5'(memrd); r.memwe = 1'(memwe);
        r.wbrd = 5'(wbrd); r.wbwe = 1'(wbwe); r.wbval = 32'h0;
        r.bj = 1'(bj);     r.im = 1'(im);     r.dm = 1'(dm);
        return r;
    endfunction

    task automatic drive(input in_t v);
        ID_RS1_ADDR = v.rs1;   ID_RS1_USED = v.u1;
        ID_RS2_ADDR = v.rs2;   ID_RS2_USED = v.u2;
        EX_RD_ADDR = v.exrd;   EX_REG_WRITE_EN = v.exwe; EX_IS_LOAD = v.exld;
        MEM_RD_ADDR = v.memrd; MEM_REG_WRITE_EN = v.memwe;
        WB_RD_ADDR = v.wbrd;   WB_REG_WRITE_EN = v.wbwe; WB_VALUE = v.wbval;
        EX_BJ_SIG = v.bj; INSTR_MEM_BUSYWAIT = v.im; DATA_MEM_BUSYWAIT = v.dm;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        RESET = 1'b1;
        cyc();
        RESET = 1'b0;
    endtask

    function automatic bit hit(input logic [4:0] a, input logic used, input logic [4:0] rd,
                               input logic we);
        return used && we && rd != 5'd0 && a == rd;
    endfunction

    // Expected control word from the priority rules: dmem wait, branch, data hazard, imem wait.
    function automatic logic [6:0] model_ctl(input in_t v, input bit ld_prev);
        bit ex_hit, lu, raw, haz;
        ex_hit = hit(v.rs1, v.u1, v.exrd, v.exwe) || hit(v.rs2, v.u2, v.exrd, v.exwe);
        lu     = v.exld && ex_hit;
        raw    = ex_hit ||
                 hit(v.rs1, v.u1, v.memrd, v.memwe) || hit(v.rs2, v.u2, v.memrd, v.memwe) ||
                 hit(v.rs1, v.u1, v.wbrd, v.wbwe)   || hit(v.rs2, v.u2, v.wbrd, v.wbwe);
        haz    = FWD ? (lu && !ld_prev) : raw;
        if (v.dm) return S_DM;
        if (v.bj) return S_BJ;
        if (haz)  return S_HAZ;
        if (v.im) return S_IM;
        return S_NONE;
    endfunction

    function automatic logic [1:0] model_src(input logic [4:0] a, input in_t v);
        if (a != 5'd0 && v.memwe && v.memrd == a) return 2'd1;
        if (a != 5'd0 && v.wbwe && v.wbrd == a)   return 2'd2;
        if (a != 5'd0 && m_pv && m_pa == a)       return 2'd3;
        return 2'd0;
    endfunction

    vec_t tbl[13];
    in_t  idle, v;
    bit   rst;
    logic [6:0] mc;
    logic [1:0] n1, n2;

    initial begin
        checks = 0;
        failures = 0;
        RESET = 1'b1;
        idle = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0);
        drive(idle);

        //               rs1 u1 rs2 u2 exrd we ld mrd mwe wrd wwe bj im dm   fwd     nofwd
        tbl[0]  = '{mk(0,0,0,0, 0,0,0, 0,0, 0,0, 0,0,0), S_NONE, S_NONE};
        tbl[1]  = '{mk(3,1,0,0, 3,1,1, 0,0, 0,0, 0,0,0), S_HAZ,  S_HAZ};
        tbl[2]  = '{mk(3,0,0,0, 3,1,1, 0,0, 0,0, 0,0,0), S_NONE, S_NONE};
        tbl[3]  = '{mk(0,1,0,1, 0,1,1, 0,0, 0,0, 0,0,0), S_NONE, S_NONE};
        tbl[4]  = '{mk(3,1,0,0, 3,1,0, 0,0, 0,0, 0,0,0), S_NONE, S_HAZ};
        tbl[5]  = '{mk(0,0,4,1, 0,0,0, 4,1, 0,0, 0,0,0), S_NONE, S_HAZ};
        tbl[6]  = '{mk(6,1,0,0, 0,0,0, 0,0, 6,1, 0,0,0), S_NONE, S_HAZ};
        tbl[7]  = '{mk(6,1,0,0, 0,0,0, 0,0, 6,0, 0,0,0), S_NONE, S_NONE};
        tbl[8]  = '{mk(0,0,0,0, 0,0,0, 0,0, 0,0, 0,1,0), S_IM,   S_IM};
        tbl[9]  = '{mk(0,0,2,1, 2,1,1, 0,0, 0,0, 0,1,0), S_HAZ,  S_HAZ};
        tbl[10] = '{mk(0,0,0,0, 0,0,0, 0,0, 0,0, 1,1,0), S_BJ,   S_BJ};
        tbl[11] = '{mk(2,1,0,0, 2,1,1, 0,0, 0,0, 1,1,1), S_DM,   S_DM};
        tbl[12] = '{mk(0,1,0,0, 0,0,0, 0,1, 0,0, 0,0,0), S_NONE, S_NONE};

        do_reset();
        @(negedge CLK);
        chk("rst_ctl", 64'(ctl), 64'(S_NONE));
        chk("rst_fsel", 64'({FWD_SEL1, FWD_SEL2}), 64'(4'h0));
        chk("rst_pwb", 64'(POSTWB_VALUE), 64'(32'h0));

        for (int k = 0; k < 13; k++) begin
            do_reset();
            drive(tbl[k].i);
            @(negedge CLK);
            chk($sformatf("vec%0d_ctl", k), 64'(ctl), 64'(FWD ? tbl[k].ef : tbl[k].en));
        end

        // add x5 in MEM, ID reads x5; then a write to x0 read as x0
        do_reset();
        v = idle; v.memrd = 5'd5; v.memwe = 1'b1; v.rs1 = 5'd5; v.u1 = 1'b1;
        drive(v);
        @(negedge CLK);
        chk("mem_fwd_ctl", 64'(ctl), 64'(FWD ? S_NONE : S_HAZ));
        cyc();
        v = idle; v.memrd = 5'd0; v.memwe = 1'b1; v.rs1 = 5'd0; v.u1 = 1'b1;
        drive(v);
        @(negedge CLK);
        chk("mem_fwd_sel1", 64'(FWD_SEL1), 64'(FWD ? 2'd1 : 2'd0));
        chk("x0_ctl", 64'(ctl), 64'(S_NONE));
        cyc();
        drive(idle);
        @(negedge CLK);
        chk("x0_fwd_sel1", 64'(FWD_SEL1), 64'(2'd0));

        // lw x7 in EX, ID reads rs2=x7
        do_reset();
        v = idle; v.exrd = 5'd7; v.exwe = 1'b1; v.exld = 1'b1; v.rs2 = 5'd7; v.u2 = 1'b1;
        drive(v);
        @(negedge CLK);
        chk("ld_use_ctl", 64'(ctl), 64'(S_HAZ));
        cyc();
        v = idle; v.memrd = 5'd7; v.memwe = 1'b1; v.rs2 = 5'd7; v.u2 = 1'b1;
        drive(v);
        @(negedge CLK);
        chk("ld_after_ctl", 64'(ctl), 64'(FWD ? S_NONE : S_HAZ));
        chk("ld_bubble_sel2", 64'(FWD_SEL2), 64'(2'd0));
        cyc();
        drive(idle);
        @(negedge CLK);
        chk("ld_fwd_sel2", 64'(FWD_SEL2), 64'(FWD ? 2'd1 : 2'd0));

        // branch concurrent with load-use and instr busywait
        do_reset();
        v = idle; v.exrd = 5'd7; v.exwe = 1'b1; v.exld = 1'b1; v.rs2 = 5'd7; v.u2 = 1'b1;
        v.bj = 1'b1; v.im = 1'b1;
        drive(v);
        @(negedge CLK);
        chk("bj_ctl", 64'(ctl), 64'(S_BJ));

        // three cycles of data busywait freeze forwarding state
        do_reset();
        v = idle; v.memrd = 5'd5; v.memwe = 1'b1; v.rs1 = 5'd5; v.u1 = 1'b1;
        v.wbrd = 5'd9; v.wbwe = 1'b1; v.wbval = 32'hDEADBEEF;
        drive(v);
        cyc();
        for (int c = 0; c < 3; c++) begin
            v = idle; v.dm = 1'b1; v.bj = 1'b1; v.im = 1'b1;
            v.memrd = 5'd2; v.memwe = 1'b1; v.rs1 = 5'd2; v.u1 = 1'b1;
            v.wbrd = 5'd3; v.wbwe = 1'b1; v.wbval = 32'h12345678;
            drive(v);
            @(negedge CLK);
            chk($sformatf("dm%0d_ctl", c), 64'(ctl), 64'(S_DM));
            chk($sformatf("dm%0d_sel1", c), 64'(FWD_SEL1), 64'(FWD ? 2'd1 : 2'd0));
            chk($sformatf("dm%0d_pwb", c), 64'(POSTWB_VALUE), 64'(32'hDEADBEEF));
            cyc();
        end
        drive(idle);
        @(negedge CLK);
        chk("dm_end_ctl", 64'(ctl), 64'(S_NONE));
        chk("dm_end_sel1", 64'(FWD_SEL1), 64'(FWD ? 2'd1 : 2'd0));
        chk("dm_end_pwb", 64'(POSTWB_VALUE), 64'(32'hDEADBEEF));

        // WB writes x9, ID reads x9 the next cycle
        do_reset();
        v = idle; v.wbrd = 5'd9; v.wbwe = 1'b1; v.wbval = 32'hDEADBEEF;
        drive(v);
        cyc();
        v = idle; v.rs1 = 5'd9; v.u1 = 1'b1;
        drive(v);
        @(negedge CLK);
        chk("pwb_ctl", 64'(ctl), 64'(S_NONE));
        cyc();
        drive(idle);
        @(negedge CLK);
        chk("pwb_sel1", 64'(FWD_SEL1), 64'(FWD ? 2'd3 : 2'd0));
        chk("pwb_value", 64'(POSTWB_VALUE), 64'(32'hDEADBEEF));

        // back-to-back dependent adds: producer walks EX, MEM, WB
        do_reset();
        for (int s = 0; s < 5; s++) begin
            v = idle;
            if (s < 4) begin
                v.rs1 = 5'd5; v.u1 = 1'b1;
            end
            if (s == 0) begin v.exrd = 5'd5;  v.exwe = 1'b1;  end
            if (s == 1) begin v.memrd = 5'd5; v.memwe = 1'b1; end
            if (s == 2) begin v.wbrd = 5'd5;  v.wbwe = 1'b1;  end
            drive(v);
            @(negedge CLK);
            chk($sformatf("raw%0d_ctl", s), 64'(ctl), 64'((!FWD && s < 3) ? S_HAZ : S_NONE));
            chk($sformatf("raw%0d_sel1", s), 64'(FWD_SEL1),
                64'(FWD ? ((s == 2) ? 2'd1 : (s == 3) ? 2'd2 : (s == 4) ? 2'd3 : 2'd0) : 2'd0));
            cyc();
        end

        // randomized run against the reference model
        for (int i = 0; i < 3000; i++) begin
            v = idle;
            v.rs1 = 5'($urandom_range(0, 3));  v.u1 = 1'($urandom_range(0, 1));
            v.rs2 = 5'($urandom_range(0, 3));  v.u2 = 1'($urandom_range(0, 1));
            v.exrd = 5'($urandom_range(0, 3)); v.exwe = 1'($urandom_range(0, 1));
            v.exld = 1'($urandom_range(0, 1));
            v.memrd = 5'($urandom_range(0, 3)); v.memwe = 1'($urandom_range(0, 1));
            v.wbrd = 5'($urandom_range(0, 3)); v.wbwe = 1'($urandom_range(0, 1));
            v.wbval = $urandom();
            v.bj = ($urandom_range(0, 7) == 0);
            v.im = ($urandom_range(0, 3) == 0);
            v.dm = ($urandom_range(0, 5) == 0);
            rst = (i == 0) || ($urandom_range(0, 39) == 0);
            drive(v);
            RESET = rst;
            @(negedge CLK);
            mc = model_ctl(v, m_ld);
            chk($sformatf("rnd%0d_ctl", i), 64'(ctl), 64'(mc));
            if (i > 0) begin
                chk($sformatf("rnd%0d_regs", i), 64'({FWD_SEL1, FWD_SEL2, POSTWB_VALUE}),
                    64'({m_f1, m_f2, m_val}));
            end
            if (rst) begin
                m_ld = 1'b0; m_pv = 1'b0; m_pa = 5'd0; m_val = 32'h0;
                m_f1 = 2'd0; m_f2 = 2'd0;
            end else if (!v.dm) begin
                m_ld = FWD && (mc == S_HAZ);
                n1 = model_src(v.rs1, v);
                n2 = model_src(v.rs2, v);
                if (FWD) begin
                    m_f1 = mc[2] ? 2'd0 : n1;
                    m_f2 = mc[2] ? 2'd0 : n2;
                end
                m_pv = v.wbwe && v.wbrd != 5'd0;
                if (m_pv) begin
                    m_pa = v.wbrd;
                    m_val = v.wbval;
                end
            end else begin
                m_ld = 1'b0;
            end
            cyc();
        end
        RESET = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
